// File: rtl/udp_ack_sender.sv
// udp_ack_sender
//   Status responder for the liteeth_core UDP sink. It watches the UDP source
//   stream going to the panel writer and, for every completed frame addressed
//   to LISTEN_PORT, sends a 12-byte status datagram back to the sender:
//     word 0 : MAGIC
//     word 1 : {rx_frames[15:0], err_frames[7:0], coalesced[7:0]}
//     word 2 : {16'h0, length of the frame that triggered the reply}
//   Replies requested while one is already waiting are merged into a single
//   reply that uses the newest sender and length.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   enable                0 blocks new replies; counters keep counting
//   rx_*                  passive snoop of udp_source_* (never back-pressured)
//   udp_sink_*            reply stream into liteeth_core (valid/ready/last)
//   busy                  reply state machine is not idle
module udp_ack_sender #(
    parameter logic [15:0] LISTEN_PORT    = 16'd6000,
    parameter logic [31:0] MAGIC          = 32'h4C454443,
    parameter bit          ENABLE_ERR_ACK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        rx_valid,
    input  logic        rx_ready,
    input  logic        rx_last,
    input  logic [15:0] rx_src_port,
    input  logic [15:0] rx_dst_port,
    input  logic [31:0] rx_ip_address,
    input  logic [15:0] rx_length,
    input  logic [3:0]  rx_error,
    output logic        udp_sink_valid,
    output logic        udp_sink_last,
    input  logic        udp_sink_ready,
    output logic [15:0] udp_sink_src_port,
    output logic [15:0] udp_sink_dst_port,
    output logic [31:0] udp_sink_ip_address,
    output logic [15:0] udp_sink_length,
    output logic [31:0] udp_sink_data,
    output logic [3:0]  udp_sink_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND0 = 3'd2,
        SEND1 = 3'd3,
        SEND2 = 3'd4
    } state_t;

    // Reply contents frozen in LOAD so counter activity during a packet
    // cannot change beats of that packet.
    typedef struct packed {
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] ip;
        logic [15:0] port;
    } snap_t;

    state_t      state, state_next;
    snap_t       snap;

    logic        pending;
    logic [15:0] rx_frames;
    logic [7:0]  err_frames;
    logic [7:0]  coalesced;
    logic [31:0] tgt_ip;
    logic [15:0] tgt_port;
    logic [15:0] last_len;

    logic        rx_event;
    logic        rx_good;
    logic        reply_req;
    logic        handshake;

    assign rx_event  = rx_valid & rx_ready & rx_last & (rx_dst_port == LISTEN_PORT);
    assign rx_good   = (rx_error == 4'h0);
    assign reply_req = rx_event & (rx_good | ENABLE_ERR_ACK);
    assign handshake = udp_sink_valid & udp_sink_ready;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // The request is looked at directly in IDLE (not only via the pending
    // register) so the first reply beat is valid two cycles after the frame's
    // last beat. Leaving SEND2 always passes through IDLE for one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if ((pending | reply_req) & enable) state_next = LOAD;
            LOAD:    state_next = SEND0;
            SEND0:   if (handshake) state_next = SEND1;
            SEND1:   if (handshake) state_next = SEND2;
            SEND2:   if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Pending flag and coalescing counter
    // ------------------------------------------------------------------
    // LOAD consumes the pending request; a request arriving in that same
    // cycle starts a new reply rather than being merged into the one
    // being snapshotted, so it is not counted as coalesced.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending   <= 1'b0;
            coalesced <= 8'h00;
        end else begin
            if (reply_req)          pending <= 1'b1;
            else if (state == LOAD) pending <= 1'b0;

            if (reply_req && pending && state != LOAD && coalesced != 8'hFF)
                coalesced <= coalesced + 8'h01;
        end
    end

    // ------------------------------------------------------------------
    // Frame counters and reply target
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_frames  <= 16'h0000;
            err_frames <= 8'h00;
        end else if (rx_event) begin
            if (rx_good)                  rx_frames  <= rx_frames + 16'h0001;
            else if (err_frames != 8'hFF) err_frames <= err_frames + 8'h01;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tgt_ip   <= 32'h0;
            tgt_port <= 16'h0;
            last_len <= 16'h0;
        end else if (reply_req) begin
            tgt_ip   <= rx_ip_address;
            tgt_port <= rx_src_port;
            last_len <= rx_length;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            snap <= '0;
        end else if (state == LOAD) begin
            snap.w1   <= {rx_frames, err_frames, coalesced};
            snap.w2   <= {16'h0000, last_len};
            snap.ip   <= tgt_ip;
            snap.port <= tgt_port;
        end
    end

    // ------------------------------------------------------------------
    // Registered sink beat
    // ------------------------------------------------------------------
    // Beat registers follow the next state, so they change only when the
    // state does; a stalled beat keeps every field steady until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            udp_sink_valid <= 1'b0;
            udp_sink_last  <= 1'b0;
            udp_sink_data  <= 32'h0;
        end else begin
            udp_sink_valid <= (state_next == SEND0) || (state_next == SEND1) ||
                              (state_next == SEND2);
            udp_sink_last  <= (state_next == SEND2);
            case (state_next)
                SEND0:   udp_sink_data <= MAGIC;
                SEND1:   udp_sink_data <= snap.w1;
                SEND2:   udp_sink_data <= snap.w2;
                default: udp_sink_data <= 32'h0;
            endcase
        end
    end

    assign udp_sink_ip_address = snap.ip;
    assign udp_sink_dst_port   = snap.port;
    assign udp_sink_src_port   = LISTEN_PORT;
    assign udp_sink_length     = 16'd12;
    assign udp_sink_error      = 4'h0;

endmodule

// File: tb/tb_udp_ack_sender.sv
// Directed bench for udp_ack_sender. A second instance with error replies
// disabled shares all inputs so both parameter settings are exercised.
module tb_udp_ack_sender;

    localparam logic [31:0] MAGIC = 32'h4C454443;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] ip;
        logic [15:0] port;
        logic [15:0] len;
        logic [15:0] sport;
        logic [3:0]  err;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset, enable;
    logic        rx_valid, rx_ready, rx_last;
    logic [15:0] rx_src_port, rx_dst_port, rx_length;
    logic [31:0] rx_ip_address;
    logic [3:0]  rx_error;
    logic        sink_ready;

    logic        valid, last, busy;
    logic [15:0] sport, dport, len;
    logic [31:0] ip, data;
    logic [3:0]  err;

    logic        n_valid, n_last, n_busy;
    logic [15:0] n_sport, n_dport, n_len;
    logic [31:0] n_ip, n_data;
    logic [3:0]  n_err;

    int n_pass = 0;
    int n_chk  = 0;

    beat_t q[$];
    beat_t qn[$];
    beat_t cap, capn;

    always #5 clock = ~clock;

    udp_ack_sender dut (
        .clock(clock), .reset(reset), .enable(enable),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_last(rx_last),
        .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port),
        .rx_ip_address(rx_ip_address), .rx_length(rx_length), .rx_error(rx_error),
        .udp_sink_valid(valid), .udp_sink_last(last), .udp_sink_ready(sink_ready),
        .udp_sink_src_port(sport), .udp_sink_dst_port(dport),
        .udp_sink_ip_address(ip), .udp_sink_length(len), .udp_sink_data(data),
        .udp_sink_error(err), .busy(busy)
    );

    udp_ack_sender #(.ENABLE_ERR_ACK(1'b0)) dut_ne (
        .clock(clock), .reset(reset), .enable(enable),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_last(rx_last),
        .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port),
        .rx_ip_address(rx_ip_address), .rx_length(rx_length), .rx_error(rx_error),
        .udp_sink_valid(n_valid), .udp_sink_last(n_last), .udp_sink_ready(sink_ready),
        .udp_sink_src_port(n_sport), .udp_sink_dst_port(n_dport),
        .udp_sink_ip_address(n_ip), .udp_sink_length(n_len), .udp_sink_data(n_data),
        .udp_sink_error(n_err), .busy(n_busy)
    );

    // Record every accepted beat of both instances.
    always @(negedge clock) begin
        if (valid && sink_ready) begin
            cap.data = data; cap.last = last; cap.ip = ip; cap.port = dport;
            cap.len = len; cap.sport = sport; cap.err = err;
            q.push_back(cap);
        end
        if (n_valid && sink_ready) begin
            capn.data = n_data; capn.last = n_last; capn.ip = n_ip; capn.port = n_dport;
            capn.len = n_len; capn.sport = n_sport; capn.err = n_err;
            qn.push_back(capn);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_beat(input string tag, input beat_t b, input logic [31:0] d,
                            input logic l, input logic [31:0] a, input logic [15:0] p);
        chk({tag, "_data"}, b.data, d);
        chk({tag, "_last"}, {31'h0, b.last}, {31'h0, l});
        chk({tag, "_ip"}, b.ip, a);
        chk({tag, "_dport"}, {16'h0, b.port}, {16'h0, p});
        chk({tag, "_len"}, {16'h0, b.len}, 32'd12);
        chk({tag, "_sport"}, {16'h0, b.sport}, 32'd6000);
        chk({tag, "_err"}, {28'h0, b.err}, 32'h0);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [15:0] sp, input logic [15:0] dp,
                              input logic [15:0] l, input logic [3:0] e, input int beats);
        for (int i = 0; i < beats; i++) begin
            @(posedge clock); #1;
            rx_valid = 1'b1; rx_ready = 1'b1; rx_last = (i == beats - 1);
            rx_ip_address = a; rx_src_port = sp; rx_dst_port = dp;
            rx_length = l; rx_error = e;
        end
        @(posedge clock); #1;
        rx_valid = 1'b0; rx_last = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; sink_ready = 1'b1;
        rx_valid = 1'b0; rx_ready = 1'b0; rx_last = 1'b0;
        rx_src_port = '0; rx_dst_port = '0; rx_ip_address = '0; rx_length = '0; rx_error = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_last",  {31'h0, last},  32'h0);
        chk("rst_data",  data, 32'h0);
        chk("rst_err",   {28'h0, err},   32'h0);
        chk("rst_busy",  {31'h0, busy},  32'h0);
        @(posedge clock); #1 reset = 1'b0;

        // Single 4-beat frame, latency and contents
        q.delete();
        send_frame(32'hC0A8010A, 16'd5000, 16'd6000, 16'd1024, 4'h0, 4);
        @(negedge clock);
        chk("lat_load_valid", {31'h0, valid}, 32'h0);
        chk("lat_load_busy",  {31'h0, busy},  32'h1);
        @(negedge clock);
        chk("lat_first_valid", {31'h0, valid}, 32'h1);
        chk("lat_first_data",  data, MAGIC);
        repeat (10) @(negedge clock);
        chk("single_n", q.size(), 32'd3);
        if (q.size() == 3) begin
            chk_beat("single_b0", q[0], MAGIC,        1'b0, 32'hC0A8010A, 16'd5000);
            chk_beat("single_b1", q[1], 32'h00010000, 1'b0, 32'hC0A8010A, 16'd5000);
            chk_beat("single_b2", q[2], 32'h00000400, 1'b1, 32'hC0A8010A, 16'd5000);
        end
        chk("single_idle", {31'h0, busy}, 32'h0);

        // Wrong port: ignored, counter untouched
        q.delete();
        send_frame(32'hC0A8010B, 16'd5000, 16'd6001, 16'd512, 4'h0, 2);
        repeat (10) @(negedge clock);
        chk("wport_n", q.size(), 32'd0);
        chk("wport_busy", {31'h0, busy}, 32'h0);
        send_frame(32'hC0A80114, 16'd5001, 16'd6000, 16'd64, 4'h0, 1);
        repeat (10) @(negedge clock);
        chk("wport_next_n", q.size(), 32'd3);
        if (q.size() == 3) begin
            chk("wport_w1", q[1].data, 32'h00020000);
            chk("wport_w2", q[2].data, 32'h00000040);
        end

        // Backpressure in SEND1
        q.delete();
        send_frame(32'h0A000001, 16'd7000, 16'd6000, 16'd256, 4'h0, 1);
        @(posedge clock); #1;
        @(posedge clock); #1 sink_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", {31'h0, valid}, 32'h1);
            chk("bp_data",  data, 32'h00030000);
            chk("bp_last",  {31'h0, last}, 32'h0);
            chk("bp_ip",    ip, 32'h0A000001);
            chk("bp_dport", {16'h0, dport}, 32'd7000);
        end
        @(posedge clock); #1 sink_ready = 1'b1;
        repeat (10) @(negedge clock);
        chk("bp_n", q.size(), 32'd3);
        if (q.size() == 3) begin
            chk_beat("bp_b1", q[1], 32'h00030000, 1'b0, 32'h0A000001, 16'd7000);
            chk_beat("bp_b2", q[2], 32'h00000100, 1'b1, 32'h0A000001, 16'd7000);
        end

        // Coalescing: three frames while the sink is stalled
        pulse_reset();
        q.delete();
        sink_ready = 1'b0;
        send_frame(32'hC0A80101, 16'd1111, 16'd6000, 16'd10, 4'h0, 1);
        send_frame(32'hC0A80102, 16'd2222, 16'd6000, 16'd20, 4'h0, 1);
        send_frame(32'hC0A80103, 16'd3333, 16'd6000, 16'd30, 4'h0, 1);
        repeat (3) @(negedge clock);
        chk("coal_stall_n", q.size(), 32'd0);
        chk("coal_stall_valid", {31'h0, valid}, 32'h1);
        @(posedge clock); #1 sink_ready = 1'b1;
        repeat (20) @(negedge clock);
        chk("coal_n", q.size(), 32'd6);
        if (q.size() == 6) begin
            chk_beat("coal_r1b0", q[0], MAGIC,        1'b0, 32'hC0A80101, 16'd1111);
            chk_beat("coal_r1b1", q[1], 32'h00010000, 1'b0, 32'hC0A80101, 16'd1111);
            chk_beat("coal_r1b2", q[2], 32'h0000000A, 1'b1, 32'hC0A80101, 16'd1111);
            chk_beat("coal_r2b0", q[3], MAGIC,        1'b0, 32'hC0A80103, 16'd3333);
            chk_beat("coal_r2b1", q[4], 32'h00030001, 1'b0, 32'hC0A80103, 16'd3333);
            chk_beat("coal_r2b2", q[5], 32'h0000001E, 1'b1, 32'hC0A80103, 16'd3333);
        end
        chk("coal_idle", {31'h0, busy}, 32'h0);

        // Error frame, with and without error replies
        pulse_reset();
        q.delete(); qn.delete();
        send_frame(32'hC0A80105, 16'd4444, 16'd6000, 16'd50, 4'h2, 1);
        repeat (10) @(negedge clock);
        chk("err_n", q.size(), 32'd3);
        if (q.size() == 3)
            chk_beat("err_b1", q[1], 32'h00000100, 1'b0, 32'hC0A80105, 16'd4444);
        chk("err_ne_n", qn.size(), 32'd0);
        send_frame(32'hC0A80106, 16'd4445, 16'd6000, 16'd60, 4'h0, 1);
        repeat (10) @(negedge clock);
        chk("err_next_n", q.size(), 32'd6);
        if (q.size() == 6) chk("err_next_w1", q[4].data, 32'h00010100);
        chk("err_ne_next_n", qn.size(), 32'd3);
        if (qn.size() == 3) begin
            chk("err_ne_w1", qn[1].data, 32'h00010100);
            chk("err_ne_w2", qn[2].data, 32'h0000003C);
            chk("err_ne_ip", qn[2].ip, 32'hC0A80106);
        end

        // Reset in the middle of SEND1
        send_frame(32'hC0A80107, 16'd5555, 16'd6000, 16'd70, 4'h0, 1);
        @(posedge clock); #1;
        @(posedge clock); #1 sink_ready = 1'b0;
        @(negedge clock);
        chk("mid_pre_valid", {31'h0, valid}, 32'h1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_valid", {31'h0, valid}, 32'h0);
        chk("mid_rst_busy",  {31'h0, busy},  32'h0);
        chk("mid_rst_data",  data, 32'h0);
        @(posedge clock); #1 reset = 1'b0; sink_ready = 1'b1;
        q.delete();
        send_frame(32'hC0A80108, 16'd6666, 16'd6000, 16'd80, 4'h0, 1);
        repeat (10) @(negedge clock);
        chk("mid_next_n", q.size(), 32'd3);
        if (q.size() == 3)
            chk_beat("mid_next_b1", q[1], 32'h00010000, 1'b0, 32'hC0A80108, 16'd6666);

        // enable low holds the request until re-enabled
        q.delete();
        enable = 1'b0;
        send_frame(32'hC0A80109, 16'd7777, 16'd6000, 16'd90, 4'h0, 1);
        repeat (10) @(negedge clock);
        chk("en_off_n", q.size(), 32'd0);
        chk("en_off_busy", {31'h0, busy}, 32'h0);
        @(posedge clock); #1 enable = 1'b1;
        repeat (10) @(negedge clock);
        chk("en_on_n", q.size(), 32'd3);
        if (q.size() == 3) begin
            chk_beat("en_on_b1", q[1], 32'h00020000, 1'b0, 32'hC0A80109, 16'd7777);
            chk_beat("en_on_b2", q[2], 32'h0000005A, 1'b1, 32'hC0A80109, 16'd7777);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
